// File: rtl/nor_check_pkg.sv
// rtl/nor_check_pkg.sv - shared types and constants for the NOR gate vector checker
package nor_check_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // err_mask / expected-vector bit positions
  localparam int unsigned BIT_AND  = 5;
  localparam int unsigned BIT_OR   = 4;
  localparam int unsigned BIT_NOT  = 3;
  localparam int unsigned BIT_NAND = 2;
  localparam int unsigned BIT_XOR  = 1;
  localparam int unsigned BIT_XNOR = 0;

  // Golden responses, [AND OR NOT NAND XOR XNOR], indexed by {A,B}
  localparam logic [5:0] EXP_VEC0 = 6'b001101;
  localparam logic [5:0] EXP_VEC1 = 6'b011110;
  localparam logic [5:0] EXP_VEC2 = 6'b010110;
  localparam logic [5:0] EXP_VEC3 = 6'b110001;

endpackage

// File: rtl/nor_expect_rom.sv
// rtl/nor_expect_rom.sv - combinational vector index to golden gate response lookup
module nor_expect_rom
  import nor_check_pkg::*;
(
  input  logic [1:0] vec_i,
  output logic [5:0] expected_o
);

  always_comb begin
    expected_o = EXP_VEC0;
    case (vec_i)
      2'd0: expected_o = EXP_VEC0;
      2'd1: expected_o = EXP_VEC1;
      2'd2: expected_o = EXP_VEC2;
      2'd3: expected_o = EXP_VEC3;
      default: expected_o = EXP_VEC0;
    endcase
  end

endmodule

// File: rtl/nor_gate_vector_checker.sv
// rtl/nor_gate_vector_checker.sv - drives all four A/B combinations into the gate block and grades its six outputs
module nor_gate_vector_checker
  import nor_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_in,
  input  logic       nand_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [2:0] fail_count,
  output logic [1:0] first_fail_vec
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [5:0] err_mask_q, err_mask_d;
  logic [2:0] fail_count_q, fail_count_d;
  logic [1:0] first_fail_q, first_fail_d;

  logic [5:0] expected;
  logic [5:0] sampled;
  logic [5:0] mismatch;

  nor_expect_rom u_rom (
    .vec_i      (vec_q),
    .expected_o (expected)
  );

  assign sampled  = {and_in, or_in, not_in, nand_in, xor_in, xnor_in};
  assign mismatch = sampled ^ expected;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_mask_d   = err_mask_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = DRIVE;
          vec_d        = 2'd0;
          a_d          = 1'b0;
          b_d          = 1'b0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_mask_d   = 6'd0;
          fail_count_d = 3'd0;
          first_fail_d = 2'd0;
        end
      end
      DRIVE: begin
        // A/B were loaded on entry so they are already stable for this cycle
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        cnt_d   = 8'd0;
        state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_mask_d = err_mask_q | mismatch;
        if (mismatch != 6'd0) begin
          fail_count_d = fail_count_q + 3'd1;
          if (fail_count_q == 3'd0) begin
            first_fail_d = vec_q;
          end
        end
        if (vec_q == 2'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (fail_count_d == 3'd0);
        end else begin
          vec_d   = vec_q + 2'd1;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= 2'd0;
      cnt_q        <= 8'd0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_mask_q   <= 6'd0;
      fail_count_q <= 3'd0;
      first_fail_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_mask_q   <= err_mask_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_mask       = err_mask_q;
  assign fail_count     = fail_count_q;
  assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_nor_gate_vector_checker.sv
// tb/tb_nor_gate_vector_checker.sv - self-checking bench for nor_gate_vector_checker
module tb_nor_gate_vector_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;

  logic       a_out, b_out, busy, done, pass;
  logic [5:0] err_mask;
  logic [2:0] fail_count;
  logic [1:0] first_fail_vec;
  logic       and_in, or_in, not_in, nand_in, xor_in, xnor_in;

  logic       a0, b0, busy0, done0, pass0;
  logic [5:0] err_mask0;
  logic [2:0] fail_count0;
  logic [1:0] first_fail0;
  logic [5:0] g0;

  logic [5:0] inj [4];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Ideal gate behaviour in [AND OR NOT NAND XOR XNOR] order
  function automatic logic [5:0] golden(input logic a, input logic b);
    return {a & b, a | b, ~a, ~(a & b), a ^ b, ~(a ^ b)};
  endfunction

  assign {and_in, or_in, not_in, nand_in, xor_in, xnor_in} = golden(a_out, b_out) ^ inj[{a_out, b_out}];
  assign g0 = golden(a0, b0);

  nor_gate_vector_checker #(.SETTLE_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .a_out          (a_out),
    .b_out          (b_out),
    .and_in         (and_in),
    .or_in          (or_in),
    .not_in         (not_in),
    .nand_in        (nand_in),
    .xor_in         (xor_in),
    .xnor_in        (xnor_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_mask       (err_mask),
    .fail_count     (fail_count),
    .first_fail_vec (first_fail_vec)
  );

  nor_gate_vector_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start0),
    .a_out          (a0),
    .b_out          (b0),
    .and_in         (g0[5]),
    .or_in          (g0[4]),
    .not_in         (g0[3]),
    .nand_in        (g0[2]),
    .xor_in         (g0[1]),
    .xnor_in        (g0[0]),
    .busy           (busy0),
    .done           (done0),
    .pass           (pass0),
    .err_mask       (err_mask0),
    .fail_count     (fail_count0),
    .first_fail_vec (first_fail0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pulses start for one edge and returns at the negedge of the done cycle; lat=1 is the cycle after the start edge
  task automatic do_run(output int lat);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    lat = done ? n : -1;
  endtask

  task automatic check_results(input string tag, input logic [5:0] m, input int c, input int f, input logic p);
    chk({tag, " err_mask"}, 64'(err_mask), 64'(m));
    chk({tag, " fail_count"}, 64'(fail_count), 64'(c));
    if (c != 0) chk({tag, " first_fail_vec"}, 64'(first_fail_vec), 64'(f));
    chk({tag, " pass"}, 64'(pass), 64'(p));
  endtask

  typedef struct {
    logic [5:0] i0, i1, i2, i3;
    logic [5:0] m;
    int         c;
    int         f;
    logic       p;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat;
    logic [31:0] ab_seen, ab_exp;
    logic [63:0] done_seen;
    logic [5:0] mm;
    int mc, mf;

    tbl[0] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'b000000, 0, 0, 1'b1};
    tbl[1] = '{6'h00, 6'b000010, 6'b000010, 6'h00, 6'b000010, 2, 1, 1'b0};
    tbl[2] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 4, 0, 1'b0};
    tbl[3] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'b000000, 0, 0, 1'b1};
    tbl[4] = '{6'h00, 6'h00, 6'h00, 6'b100000, 6'b100000, 1, 3, 1'b0};
    tbl[5] = '{6'b000001, 6'h00, 6'b110000, 6'h00, 6'b110001, 2, 0, 1'b0};
    for (int v = 0; v < 4; v++) inj[v] = 6'd0;

    repeat (3) @(negedge clk);
    chk("reset a_out", 64'(a_out), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    check_results("reset", 6'd0, 0, 0, 1'b0);
    chk("reset first_fail_vec", 64'(first_fail_vec), 64'd0);
    rst_n = 1'b1;

    // Timing run: A/B sequence, busy/done cycles, start ignored while busy
    @(negedge clk);
    start = 1'b1;
    ab_seen = '0;
    ab_exp = '0;
    done_seen = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 4) start = 1'b1;
      if (n == 5) start = 1'b0;
      if (n == 1) chk("busy after start", 64'(busy), 64'd1);
      if (n <= 16) begin
        ab_seen[2*(n-1) +: 2] = {a_out, b_out};
        ab_exp[2*(n-1) +: 2] = 2'((n - 1) / 4);
      end
      done_seen[n] = done;
      if (n == 17) chk("busy in done cycle", 64'(busy), 64'd0);
    end
    chk("a/b drive sequence", 64'(ab_seen), 64'(ab_exp));
    chk("single done at t+17", done_seen, 64'(1) << 17);
    check_results("timing", 6'd0, 0, 0, 1'b1);

    // start held high for 40 edges
    @(negedge clk);
    start = 1'b1;
    done_seen = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      done_seen[n] = done;
      if (n == 40) start = 1'b0;
    end
    chk("held start dones", done_seen, (64'(1) << 17) | (64'(1) << 35));
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    chk("held start run drains", 64'(busy), 64'd0);
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      inj[0] = tbl[k].i0;
      inj[1] = tbl[k].i1;
      inj[2] = tbl[k].i2;
      inj[3] = tbl[k].i3;
      do_run(lat);
      chk($sformatf("tbl%0d latency", k), 64'(lat), 64'd17);
      check_results($sformatf("tbl%0d", k), tbl[k].m, tbl[k].c, tbl[k].f, tbl[k].p);
      @(negedge clk);
      chk($sformatf("tbl%0d done pulse", k), 64'(done), 64'd0);
    end

    // Reset during SETTLE of vec2 with a failing model
    for (int v = 0; v < 4; v++) inj[v] = 6'b001000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset on vec2", 64'({a_out, b_out}), 64'(2'b10));
    chk("pre-reset err_mask", 64'(err_mask), 64'(6'b001000));
    rst_n = 1'b0;
    #1;
    chk("midrun reset a_out", 64'(a_out), 64'd0);
    chk("midrun reset busy", 64'(busy), 64'd0);
    check_results("midrun reset", 6'd0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) inj[v] = 6'd0;
    do_run(lat);
    chk("post-reset latency", 64'(lat), 64'd17);
    check_results("post-reset", 6'd0, 0, 0, 1'b1);

    // Randomized fault injection against a behavioural grading model
    for (int r = 0; r < 20; r++) begin
      mm = '0;
      mc = 0;
      mf = -1;
      for (int v = 0; v < 4; v++) begin
        inj[v] = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
        mm |= inj[v];
        if (inj[v] != 6'd0) begin
          mc++;
          if (mf < 0) mf = v;
        end
      end
      do_run(lat);
      chk($sformatf("rnd%0d latency", r), 64'(lat), 64'd17);
      check_results($sformatf("rnd%0d", r), mm, mc, mf, mc == 0);
    end

    // SETTLE_CYCLES=0 instance
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    lat = -1;
    for (int n = 1; n < 100; n++) begin
      if (done0) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    chk("s0 latency", 64'(lat), 64'd9);
    chk("s0 pass", 64'(pass0), 64'd1);
    chk("s0 err_mask", 64'(err_mask0), 64'd0);
    chk("s0 fail_count", 64'(fail_count0), 64'd0);
    chk("s0 busy", 64'(busy0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nor_gate_vector_checker.md
Name: nor_gate_vector_checker

Overview:
- Self-checking stimulus/response stage wrapped around the NOR-built gate block (AND, OR, NOT, NAND, XOR, XNOR).
- Upstream side: on a start pulse, drives A/B through all four input combinations.
- Downstream side: after a programmable settle time, samples the six gate outputs and compares each against the golden truth table.
- Results are summarised as an error mask, a failure count and a pass flag, so the gate block can be exercised on hardware or in a clocked bench without a human reading printouts.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling the gate outputs. Legal range is 0..255.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a run. Sampled only in IDLE; ignored otherwise.
- a_out  out  1  drives gate block input A.
- b_out  out  1  drives gate block input B.
- and_in, or_in, not_in, nand_in, xor_in, xnor_in  in  1 each  gate block outputs. not_in is NOT A.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  last completed run had zero mismatches.
- err_mask  out  6  sticky per-gate mismatch bits. Bit order: [5] AND, [4] OR, [3] NOT, [2] NAND, [1] XOR, [0] XNOR.
- fail_count  out  3  number of vectors (0..4) with at least one mismatch.
- first_fail_vec  out  2  index of the first failing vector. Meaningful only when fail_count != 0.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - a_out=0, b_out=0, busy=0, done=0, pass=0, err_mask=0, fail_count=0, first_fail_vec=0.
  - Vector index and settle counter are cleared.
  - Reset asserted mid-run aborts the run immediately with the same values.
- Vector index vec (2 bits) maps to inputs as A=vec[1], B=vec[0]. Order is 00, 01, 10, 11.
- Expected outputs, in [AND OR NOT NAND XOR XNOR] order:
  - vec0: 001101
  - vec1: 011110
  - vec2: 010110
  - vec3: 110001
- IDLE:
  - Outputs hold the previous run's results.
  - start=1 moves to DRIVE and sets vec=0.
  - On the same edge: err_mask, fail_count, first_fail_vec and pass clear; busy sets.
- DRIVE (1 cycle):
  - a_out/b_out are registered from vec.
  - Settle counter loads 0.
  - Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE:
  - Counter increments each cycle.
  - Moves to CHECK after exactly SETTLE_CYCLES cycles in SETTLE.
- CHECK (1 cycle):
  - Sample the six inputs and form mismatch = sampled XOR expected[vec].
  - err_mask |= mismatch.
  - If mismatch != 0: fail_count increments, and first_fail_vec takes vec if fail_count was 0.
  - If vec==3, go to DONE. Otherwise vec increments and the FSM returns to DRIVE.
- DONE (1 cycle):
  - done=1 and busy=0.
  - pass is set to (fail_count==0), using the value after the final CHECK update.
  - Next state is IDLE. Results hold until the next accepted start.
- Timing:
  - a_out/b_out stay stable from DRIVE through CHECK of each vector.
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - If start is sampled at edge t, busy is high from t+1 and done pulses in cycle t+1+4*(SETTLE_CYCLES+2). For the default this is t+17.
- Boundary cases:
  - start held high continuously: a new run is accepted every time the FSM is in IDLE. Back-to-back runs have one IDLE cycle between them.
  - start asserted during busy or DONE: ignored, no effect.
  - fail_count saturates naturally at 4 and cannot wrap.
  - Gate inputs are treated as known values. No X handling is required in RTL.

Decomposition:
- Package nor_check_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CHECK, DONE);
  - the err_mask bit-index constants;
  - the four 6-bit expected-vector constants.
- One sub-module, nor_expect_rom: combinational vec[1:0] -> expected[5:0] lookup, used by CHECK.

Test Plan:
- Correct gate block connected, SETTLE_CYCLES=2, start pulse at t → a_out/b_out sequence 00, 01, 10, 11; done at t+17; pass=1, err_mask=0, fail_count=0.
- Model with XOR stuck at 0 → err_mask=000010, fail_count=2 (vec1, vec2), first_fail_vec=1, pass=0.
- Model with NOT output inverted → err_mask=001000, fail_count=4, first_fail_vec=0; a second run with the correct model clears everything and reports pass=1.
- rst_n asserted during SETTLE of vec2 → all outputs return to reset values immediately, and a following start runs a full clean pass.
- start re-pulsed while busy, plus start held high for 40 cycles → no restart mid-run; two complete runs, with done at t+17 and t+35.
- SETTLE_CYCLES=0 → each vector takes 2 cycles and done arrives at t+9; results match the correct model.
